sprite_plot_scheduler: RTL and testbench
========================================

# sprite_plot_scheduler

Frame-level controller that owns the single VGA adapter write port and shares it between the obstacle sprite and the player sprite. On every frame tick it latches both sprites' new top-left positions, erases each sprite at its previously drawn position with the background colour, then draws each at its new position. Every sprite is a 4x4 block, plotted one pixel per clock. The block sits between the per-frame motion logic (obstacle mover, player input) and the VGA adapter. It also reports a per-frame collision flag to the game FSM.

## Interface
Parameters:
- BG_COLOUR, 3'd0, colour used for erase passes
- OBS_COLOUR, 3'd2, obstacle draw colour
- PLY_COLOUR, 3'd4, player draw colour

Ports:
- clock  in  1  system clock (50 MHz)
- resetn  in  1  synchronous, active-low reset, sampled on the rising edge of clock
- frame_tick  in  1  one-cycle pulse, once per frame
- obs_x  in  8  obstacle top-left x, sampled on accepted tick
- obs_y  in  7  obstacle top-left y, sampled on accepted tick
- ply_x  in  8  player top-left x, sampled on accepted tick
- ply_y  in  7  player top-left y, sampled on accepted tick
- x  out  8  pixel x to VGA adapter
- y  out  7  pixel y to VGA adapter
- colour  out  3  pixel colour to VGA adapter
- writeEn  out  1  pixel write strobe
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a frame sequence completes
- collision  out  1  sprites overlapped in the most recently completed frame
- overrun  out  1  sticky: a frame_tick arrived while busy

## Operation
- States: IDLE, ERASE_OBS, ERASE_PLY, DRAW_OBS, DRAW_PLY, DONE.
- Registers:
  - new_ox/new_oy/new_px/new_py: latched positions
  - old_ox/old_oy/old_px/old_py: last drawn positions
  - have_old: old positions valid
  - cnt[3:0]: pixel counter
- IDLE with frame_tick=1:
  - latch all four position inputs into new_*
  - cnt<=0
  - go to ERASE_OBS if have_old=1, else DRAW_OBS
- Each pixel state lasts exactly 16 cycles, cnt 0..15.
  - On cnt=15: cnt<=0 and advance.
  - Order: ERASE_OBS -> ERASE_PLY -> DRAW_OBS -> DRAW_PLY -> DONE.
- Pixel outputs are combinational from state, cnt and the base register:
  - x = base_x + cnt[1:0]
  - y = base_y + cnt[3:2]
  - Sums are truncated to 8 bits for x (wraps mod 256) and 7 bits for y (wraps mod 128).
- Base and colour per state:
  - ERASE_OBS: base old_o*, colour BG_COLOUR
  - ERASE_PLY: base old_p*, colour BG_COLOUR
  - DRAW_OBS: base new_o*, colour OBS_COLOUR
  - DRAW_PLY: base new_p*, colour PLY_COLOUR
- writeEn=1 in the four pixel states, 0 in IDLE and DONE.
- In IDLE and DONE, x/y/colour hold 0.
- DONE lasts one cycle:
  - done=1
  - old_* <= new_*; have_old<=1
  - collision <= (|new_ox-new_px| < 4) and (|new_oy-new_py| < 4), using 9-bit/8-bit signed differences, no wrap
  - next state IDLE
- A frame_tick in any non-IDLE state is ignored: positions are not re-latched and the sequence is not restarted. overrun<=1 and stays set until reset.
- A frame_tick in DONE is also ignored and sets overrun.
- Position inputs are don't-care except on the accepting edge.

## Timing
- Reset values:
  - State IDLE, cnt=0, have_old=0
  - All old_*/new_*=0
  - x=0, y=0, colour=0, writeEn=0, busy=0, done=0, collision=0, overrun=0
- Reset mid-sequence: the next cycle after the resetn=0 edge is IDLE with writeEn=0. The frame is abandoned and the next frame draws without erasing.
- Latency from the accepting edge to the first pixel: the next cycle has writeEn=1 with cnt=0.
- Frame length:
  - steady state (have_old=1): 64 pixel cycles + 1 DONE cycle
  - first frame after reset: 32 + 1
- done asserts exactly 65 (or 33) cycles after the accepting edge.
- busy rises in the first pixel cycle and falls on the cycle after DONE.
- Back-to-back: a tick in the first IDLE cycle after DONE is accepted with no dead cycle.

## Test plan
- Reset, then tick with obs=(10,58), ply=(50,58):
  - 32 writeEn cycles: (10..13, 58..61) colour 2, then (50..53, 58..61) colour 4
  - done at cycle 33, collision=0
- Second tick with obs=(11,58), ply=(50,58):
  - erase (10,58) block and (50,58) block with colour 0
  - then draw (11,58) and (50,58)
  - 64 writeEn cycles, done at cycle 65
- obs=(48,57), ply=(50,58) -> collision=1 after DONE.
- obs=(46,58), ply=(50,58) -> collision=0 (edge, distance 4).
- obs=(254,126):
  - draw pixels wrap to x=254,255,0,1 and y=126,127,0,1
  - collision computed without wrap
- Tick pulsed at cycle 20 of a sequence:
  - ignored, overrun=1, sequence completes unchanged
- resetn=0 at cycle 30: IDLE next cycle, and the following tick draws only (32 cycles).

Source files
------------

// File: rtl/sprite_plot_scheduler.sv
// sprite_plot_scheduler
// Owns the single VGA write port for one frame at a time: on an accepted
// frame tick it erases both 4x4 sprites at their last drawn positions and
// then draws them at the freshly latched positions, one pixel per clock.
// At the end of each frame it publishes a collision flag for the game FSM.

module sprite_plot_scheduler #(
    parameter logic [2:0] BG_COLOUR  = 3'd0,
    parameter logic [2:0] OBS_COLOUR = 3'd2,
    parameter logic [2:0] PLY_COLOUR = 3'd4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic [7:0] obs_x,
    input  logic [6:0] obs_y,
    input  logic [7:0] ply_x,
    input  logic [6:0] ply_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       writeEn,
    output logic       busy,
    output logic       done,
    output logic       collision,
    output logic       overrun
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ERASE_OBS = 3'd1,
        ST_ERASE_PLY = 3'd2,
        ST_DRAW_OBS  = 3'd3,
        ST_DRAW_PLY  = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic [3:0] cnt_r;

    logic [7:0] new_ox_r;
    logic [6:0] new_oy_r;
    logic [7:0] new_px_r;
    logic [6:0] new_py_r;
    logic [7:0] old_ox_r;
    logic [6:0] old_oy_r;
    logic [7:0] old_px_r;
    logic [6:0] old_py_r;
    logic       have_old_r;
    logic       collision_r;
    logic       overrun_r;

    logic       accept_s;
    logic       pixel_state_s;
    logic       last_pixel_s;
    logic [7:0] base_x_s;
    logic [6:0] base_y_s;
    logic [2:0] colour_s;

    // True when two x coordinates are closer than one sprite width (no wrap).
    function automatic logic near_x(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d > -9'sd4) && (d < 9'sd4);
    endfunction

    // True when two y coordinates are closer than one sprite height (no wrap).
    function automatic logic near_y(input logic [6:0] a, input logic [6:0] b);
        logic signed [7:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d > -8'sd4) && (d < 8'sd4);
    endfunction

    // Decode handshake conditions shared by the FSM and the datapath.
    always_comb begin
        accept_s      = (state_r == ST_IDLE) && frame_tick;
        last_pixel_s  = (cnt_r == 4'd15);
        pixel_state_s = (state_r == ST_ERASE_OBS) || (state_r == ST_ERASE_PLY) ||
                        (state_r == ST_DRAW_OBS)  || (state_r == ST_DRAW_PLY);
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: each pixel pass runs 16 cycles, DONE runs one.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_next_s = have_old_r ? ST_ERASE_OBS : ST_DRAW_OBS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ERASE_OBS: state_next_s = last_pixel_s ? ST_ERASE_PLY : ST_ERASE_OBS;
            ST_ERASE_PLY: state_next_s = last_pixel_s ? ST_DRAW_OBS  : ST_ERASE_PLY;
            ST_DRAW_OBS:  state_next_s = last_pixel_s ? ST_DRAW_PLY  : ST_DRAW_OBS;
            ST_DRAW_PLY:  state_next_s = last_pixel_s ? ST_DONE      : ST_DRAW_PLY;
            ST_DONE:      state_next_s = ST_IDLE;
            default:      state_next_s = ST_IDLE;
        endcase
    end

    // Pixel counter: restarts on acceptance, wraps 15->0 between passes.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_r <= 4'd0;
        end else if (accept_s) begin
            cnt_r <= 4'd0;
        end else if (pixel_state_s) begin
            cnt_r <= last_pixel_s ? 4'd0 : (cnt_r + 4'd1);
        end else begin
            cnt_r <= 4'd0;
        end
    end

    // Latch the new sprite positions on the accepting tick only.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            new_ox_r <= 8'd0;
            new_oy_r <= 7'd0;
            new_px_r <= 8'd0;
            new_py_r <= 7'd0;
        end else if (accept_s) begin
            new_ox_r <= obs_x;
            new_oy_r <= obs_y;
            new_px_r <= ply_x;
            new_py_r <= ply_y;
        end else begin
            new_ox_r <= new_ox_r;
            new_oy_r <= new_oy_r;
            new_px_r <= new_px_r;
            new_py_r <= new_py_r;
        end
    end

    // On frame completion remember what was drawn and evaluate overlap.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            old_ox_r    <= 8'd0;
            old_oy_r    <= 7'd0;
            old_px_r    <= 8'd0;
            old_py_r    <= 7'd0;
            have_old_r  <= 1'b0;
            collision_r <= 1'b0;
        end else if (state_r == ST_DONE) begin
            old_ox_r    <= new_ox_r;
            old_oy_r    <= new_oy_r;
            old_px_r    <= new_px_r;
            old_py_r    <= new_py_r;
            have_old_r  <= 1'b1;
            collision_r <= near_x(new_ox_r, new_px_r) && near_y(new_oy_r, new_py_r);
        end else begin
            old_ox_r    <= old_ox_r;
            old_oy_r    <= old_oy_r;
            old_px_r    <= old_px_r;
            old_py_r    <= old_py_r;
            have_old_r  <= have_old_r;
            collision_r <= collision_r;
        end
    end

    // Sticky flag: a tick that could not be accepted because a frame was running.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            overrun_r <= 1'b0;
        end else if (frame_tick && (state_r != ST_IDLE)) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    // Select the sprite base and colour for the current pass.
    always_comb begin
        base_x_s = 8'd0;
        base_y_s = 7'd0;
        colour_s = 3'd0;
        case (state_r)
            ST_ERASE_OBS: begin
                base_x_s = old_ox_r;
                base_y_s = old_oy_r;
                colour_s = BG_COLOUR;
            end
            ST_ERASE_PLY: begin
                base_x_s = old_px_r;
                base_y_s = old_py_r;
                colour_s = BG_COLOUR;
            end
            ST_DRAW_OBS: begin
                base_x_s = new_ox_r;
                base_y_s = new_oy_r;
                colour_s = OBS_COLOUR;
            end
            ST_DRAW_PLY: begin
                base_x_s = new_px_r;
                base_y_s = new_py_r;
                colour_s = PLY_COLOUR;
            end
            default: begin
                base_x_s = 8'd0;
                base_y_s = 7'd0;
                colour_s = 3'd0;
            end
        endcase
    end

    // Drive the VGA port; coordinates wrap naturally at the register widths.
    always_comb begin
        if (pixel_state_s) begin
            x       = base_x_s + {6'd0, cnt_r[1:0]};
            y       = base_y_s + {5'd0, cnt_r[3:2]};
            colour  = colour_s;
            writeEn = 1'b1;
        end else begin
            x       = 8'd0;
            y       = 7'd0;
            colour  = 3'd0;
            writeEn = 1'b0;
        end
        busy      = (state_r != ST_IDLE);
        done      = (state_r == ST_DONE);
        collision = collision_r;
        overrun   = overrun_r;
    end

endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// Testbench for sprite_plot_scheduler: table of frames with hand-computed
// collision results, hand-written overrun/reset sequences, and random frames,
// all checked pixel by pixel against a queue-based reference model.

module tb_sprite_plot_scheduler;

    logic       clock = 1'b0;
    logic       resetn;
    logic       frame_tick;
    logic [7:0] obs_x;
    logic [6:0] obs_y;
    logic [7:0] ply_x;
    logic [6:0] ply_y;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       writeEn;
    logic       busy;
    logic       done;
    logic       collision;
    logic       overrun;

    always #5 clock = ~clock;

    sprite_plot_scheduler dut (
        .clock      (clock),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .obs_x      (obs_x),
        .obs_y      (obs_y),
        .ply_x      (ply_x),
        .ply_y      (ply_y),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .writeEn    (writeEn),
        .busy       (busy),
        .done       (done),
        .collision  (collision),
        .overrun    (overrun)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        logic [7:0] ox;
        logic [6:0] oy;
        logic [7:0] px;
        logic [6:0] py;
        logic       exp_col;
    } vec_t;

    // reference model state
    bit         m_have_old;
    logic [7:0] m_old_ox, m_old_px;
    logic [6:0] m_old_oy, m_old_py;
    bit         m_collision;
    bit         m_overrun;
    pix_t       exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // queue the 16 pixels of a 4x4 block in raster order
    task automatic add_block(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] c);
        for (int r = 0; r < 4; r++) begin
            for (int col = 0; col < 4; col++) begin
                pix_t p;
                p.x = 8'((int'(bx) + col) % 256);
                p.y = 7'((int'(by) + r) % 128);
                p.c = c;
                exp_q.push_back(p);
            end
        end
    endtask

    function automatic bit model_collide(input logic [7:0] ox, input logic [6:0] oy,
                                         input logic [7:0] px, input logic [6:0] py);
        int dx, dy;
        dx = int'(ox) - int'(px);
        dy = int'(oy) - int'(py);
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        return (dx < 4) && (dy < 4);
    endfunction

    task automatic randomize_positions();
        obs_x = 8'($urandom);
        obs_y = 7'($urandom);
        ply_x = 8'($urandom);
        ply_y = 7'($urandom);
    endtask

    // Called at a negedge; drives the tick now and checks the whole frame.
    // inject_at>0 pulses an extra tick after sampling that cycle of the frame.
    task automatic run_frame(input logic [7:0] ox, input logic [6:0] oy,
                             input logic [7:0] px, input logic [6:0] py,
                             input int inject_at, input string tag);
        int n;
        exp_q.delete();
        if (m_have_old) begin
            add_block(m_old_ox, m_old_oy, 3'd0);
            add_block(m_old_px, m_old_py, 3'd0);
        end
        add_block(ox, oy, 3'd2);
        add_block(px, py, 3'd4);
        n = exp_q.size();
        frame_tick = 1'b1;
        obs_x = ox; obs_y = oy; ply_x = px; ply_y = py;
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clock);
            if (k <= n) begin
                check({tag, " pixel"}, {11'd0, writeEn, busy, done, x, y, colour},
                      {11'd0, 1'b1, 1'b1, 1'b0, exp_q[k-1].x, exp_q[k-1].y, exp_q[k-1].c});
            end else begin
                check({tag, " done"}, {11'd0, writeEn, busy, done, x, y, colour},
                      {11'd0, 1'b0, 1'b1, 1'b1, 8'd0, 7'd0, 3'd0});
            end
            frame_tick = (k == inject_at);
            if (k == inject_at) m_overrun = 1'b1;
            randomize_positions();
        end
        @(negedge clock);
        frame_tick = 1'b0;
        m_have_old  = 1'b1;
        m_old_ox = ox; m_old_oy = oy; m_old_px = px; m_old_py = py;
        m_collision = model_collide(ox, oy, px, py);
        check({tag, " idle"}, {27'd0, writeEn, busy, done, collision, overrun},
              {27'd0, 1'b0, 1'b0, 1'b0, m_collision, m_overrun});
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'd10,  7'd58,  8'd50,  7'd58,  1'b0};
        vecs[1] = '{8'd11,  7'd58,  8'd50,  7'd58,  1'b0};
        vecs[2] = '{8'd48,  7'd57,  8'd50,  7'd58,  1'b1};
        vecs[3] = '{8'd46,  7'd58,  8'd50,  7'd58,  1'b0};
        vecs[4] = '{8'd50,  7'd54,  8'd50,  7'd58,  1'b0};
        vecs[5] = '{8'd254, 7'd126, 8'd252, 7'd124, 1'b1};
        vecs[6] = '{8'd254, 7'd126, 8'd1,   7'd1,   1'b0};
        vecs[7] = '{8'd52,  7'd61,  8'd50,  7'd58,  1'b1};

        resetn = 1'b0;
        frame_tick = 1'b0;
        obs_x = 8'd0; obs_y = 7'd0; ply_x = 8'd0; ply_y = 7'd0;
        m_have_old = 0; m_collision = 0; m_overrun = 0;
        m_old_ox = 8'd0; m_old_oy = 7'd0; m_old_px = 8'd0; m_old_py = 7'd0;
        repeat (3) @(negedge clock);
        check("reset outputs", {8'd0, writeEn, busy, done, collision, overrun, x, y, colour}, 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        check("idle after reset", {8'd0, writeEn, busy, done, collision, overrun, x, y, colour}, 32'd0);

        // table of frames, issued back to back
        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].ox, vecs[i].oy, vecs[i].px, vecs[i].py, 0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d collision", i), {31'd0, collision}, {31'd0, vecs[i].exp_col});
        end

        // tick in the middle of a frame is ignored and flags overrun
        run_frame(8'd12, 7'd40, 8'd60, 7'd20, 20, "mid_tick");
        check("overrun sticky", {31'd0, overrun}, 32'd1);

        // tick during DONE is also ignored
        run_frame(8'd13, 7'd41, 8'd61, 7'd21, 65, "done_tick");

        // reset in the middle of a frame abandons it
        frame_tick = 1'b1;
        obs_x = 8'd30; obs_y = 7'd30; ply_x = 8'd80; ply_y = 7'd80;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            frame_tick = 1'b0;
        end
        resetn = 1'b0;
        @(negedge clock);
        check("mid reset", {8'd0, writeEn, busy, done, collision, overrun, x, y, colour}, 32'd0);
        resetn = 1'b1;
        m_have_old = 0; m_collision = 0; m_overrun = 0;
        @(negedge clock);
        run_frame(8'd100, 7'd100, 8'd102, 7'd99, 0, "post_reset");

        // random frames with occasional ignored ticks
        for (int i = 0; i < 20; i++) begin
            int inj;
            inj = 0;
            if ($urandom_range(0, 3) == 0) inj = $urandom_range(1, m_have_old ? 65 : 33);
            run_frame(8'($urandom), 7'($urandom), 8'($urandom), 7'($urandom), inj,
                      $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
